// File: rtl/input_link_pkg.sv
// Shared constants, index map and state type for the virtual-input link.
// Code numbers double as bit positions in the mirrored input vector.
package input_link_pkg;

    localparam int NUM_INPUTS   = 22;
    localparam int NUM_BUTTONS  = 4;
    localparam int NUM_SWITCHES = 18;

    localparam int IDX_BUTTON_BASE = 0;
    localparam int IDX_SWITCH_BASE = 4;

    localparam logic [4:0]  CODE_RESYNC   = 5'd31;
    localparam logic [21:0] DEFAULT_STATE = 22'h00000F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_GAP
    } enc_state_e;

    // code 0 is button3, code 4 is switch17: both groups are bit-reversed
    function automatic logic [NUM_INPUTS-1:0] map_inputs(
        input logic [NUM_BUTTONS-1:0]  btn,
        input logic [NUM_SWITCHES-1:0] sw
    );
        logic [NUM_INPUTS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            v[IDX_BUTTON_BASE + i] = btn[NUM_BUTTONS-1-i];
        end
        for (int j = 0; j < NUM_SWITCHES; j++) begin
            v[IDX_SWITCH_BASE + j] = sw[NUM_SWITCHES-1-j];
        end
        return v;
    endfunction

    function automatic logic [4:0] lowest_index(
        input logic [NUM_INPUTS-1:0] v
    );
        logic [4:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (v[i] && !found) begin
                idx   = 5'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_bits.sv
// Multi-bit flop-chain synchronizer; async reset loads a chosen pattern
// so the chain comes out of reset agreeing with the link's defaults.
module sync_bits #(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/input_encoder.sv
// Serialises button/switch level changes into (number, control) toggle
// commands, tracking a mirror of the far-end decoder's state.
module input_encoder
    import input_link_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  button,
    input  logic [17:0] switch,
    input  logic        resync_req,
    output logic [4:0]  number,
    output logic        control,
    output logic        busy
);

    localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ?
                             PULSE_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    logic [NUM_INPUTS-1:0] in_raw;
    logic [NUM_INPUTS-1:0] in_sync;
    logic [NUM_INPUTS-1:0] diff;

    enc_state_e            state_q, state_d;
    logic [4:0]            number_q, number_d;
    logic                  control_q, control_d;
    logic                  busy_q, busy_d;
    logic                  pend_q, pend_d;
    logic [NUM_INPUTS-1:0] mirror_q, mirror_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    assign in_raw = map_inputs(button, switch);

    sync_bits #(
        .WIDTH     (NUM_INPUTS),
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (DEFAULT_STATE)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (in_raw),
        .q_o     (in_sync)
    );

    assign diff = in_sync ^ mirror_q;

    always_comb begin
        state_d   = state_q;
        number_d  = number_q;
        control_d = control_q;
        mirror_d  = mirror_q;
        pend_d    = pend_q;
        cnt_d     = cnt_q;

        if (resync_req) begin
            pend_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    state_d  = ST_SETUP;
                    number_d = CODE_RESYNC;
                end else if (|diff) begin
                    state_d  = ST_SETUP;
                    number_d = lowest_index(diff);
                end
            end
            ST_SETUP: begin
                // the far end acts on the rising edge, so commit here
                state_d   = ST_PULSE;
                control_d = 1'b1;
                cnt_d     = CW'(PULSE_CYCLES - 1);
                if (number_q == CODE_RESYNC) begin
                    mirror_d = DEFAULT_STATE;
                    pend_d   = 1'b0;
                end else if (int'(number_q) < NUM_INPUTS) begin
                    mirror_d[number_q] = ~mirror_q[number_q];
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    state_d   = ST_GAP;
                    control_d = 1'b0;
                    cnt_d     = CW'(GAP_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                control_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE)
               | (|(in_sync ^ mirror_d))
               | pend_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            number_q  <= CODE_RESYNC;
            control_q <= 1'b0;
            busy_q    <= 1'b1;
            pend_q    <= 1'b1;
            mirror_q  <= DEFAULT_STATE;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            number_q  <= number_d;
            control_q <= control_d;
            busy_q    <= busy_d;
            pend_q    <= pend_d;
            mirror_q  <= mirror_d;
            cnt_q     <= cnt_d;
        end
    end

    assign number  = number_q;
    assign control = control_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_input_encoder.sv
// Bench for input_encoder: models the far-end decoder and checks that it
// converges on the input levels, plus directed latency/ordering cases.
module tb_input_encoder;

    localparam int          PULSE  = 4;
    localparam int          GAP    = 4;
    localparam logic [21:0] TB_DEF = 22'h00000F;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  button = 4'hF;
    logic [17:0] switch = '0;
    logic        resync_req = 1'b0;
    logic [4:0]  number;
    logic        control;
    logic        busy;

    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    logic [21:0] far    = 22'h2A5A5A;
    int          cmds[$];
    int          rises[$];
    int          exp_q[$];
    logic        prev_ctrl = 1'b0;
    int          hi_cnt = 0;
    logic [4:0]  rise_num = '0;

    input_encoder #(
        .PULSE_CYCLES (PULSE),
        .GAP_CYCLES   (GAP),
        .SYNC_STAGES  (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .button     (button),
        .switch     (switch),
        .resync_req (resync_req),
        .number     (number),
        .control    (control),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Levels the far end should hold: code c<4 is button(3-c),
    // otherwise switch(21-c).
    function automatic logic [21:0] want();
        logic [21:0] v;
        for (int c = 0; c < 22; c++) begin
            v[c] = (c < 4) ? button[3-c] : switch[21-c];
        end
        return v;
    endfunction

    task automatic push_nondefault();
        logic [21:0] w;
        logic [21:0] d;
        w = want();
        d = TB_DEF;
        for (int c = 0; c < 22; c++) begin
            if (w[c] != d[c]) exp_q.push_back(c);
        end
    endtask

    task automatic check_cmds(input string tag);
        int n;
        chk({tag, "_count"}, cmds.size(), exp_q.size());
        n = (cmds.size() < exp_q.size()) ? cmds.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_cmd%0d", tag, i), cmds[i], exp_q[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        repeat (5) @(negedge clk);
        n = 0;
        while (busy !== 1'b0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_ctl0"}, control, 0);
    endtask

    task automatic wait_cmd(input string tag, input logic [4:0] code);
        int n;
        n = 0;
        while (!(control === 1'b1 && number === code) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_seen"}, number, code);
    endtask

    // Far-end decoder model: acts on each control rising edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_ctrl = 1'b0;
            hi_cnt    = 0;
        end else begin
            if (control && !prev_ctrl) begin
                if (number == 5'd31) far = TB_DEF;
                else if (number < 5'd22) far[number] = ~far[number];
                cmds.push_back(number);
                rises.push_back(cyc);
                rise_num = number;
                hi_cnt   = 1;
            end else if (control) begin
                hi_cnt++;
            end else if (prev_ctrl) begin
                chk("pulse_width", hi_cnt, PULSE);
                chk("num_stable", number, rise_num);
            end
            prev_ctrl = control;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        int idx;

        repeat (3) @(negedge clk);
        chk("rst_number", number, 31);
        chk("rst_control", control, 0);
        chk("rst_busy", busy, 1);
        step();
        reset_n = 1'b1;

        cmds.delete();
        k = 0;
        while (control !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("boot_num", number, 31);
        chk("boot_ctl", control, 1);
        wait_idle("boot");
        exp_q = {31};
        check_cmds("boot");
        chk("boot_far", far, want());
        repeat (20) @(negedge clk);
        chk("quiet", cmds.size(), 1);

        cmds.delete();
        step();
        switch[0] = 1'b1;
        repeat (2) step();
        chk("lat_t2_ctl", control, 0);
        step();
        chk("lat_t3_num", number, 21);
        chk("lat_t3_ctl", control, 0);
        step();
        chk("lat_t4_ctl", control, 1);
        repeat (3) step();
        chk("lat_t7_ctl", control, 1);
        step();
        chk("lat_t8_ctl", control, 0);
        chk("lat_t8_num", number, 21);
        wait_idle("lat");
        exp_q = {21};
        check_cmds("lat");

        cmds.delete();
        rises.delete();
        step();
        button[3] = 1'b0;
        switch[17] = 1'b1;
        wait_idle("pair");
        exp_q = {0, 4};
        check_cmds("pair");
        if (rises.size() == 2) chk("pair_period", rises[1] - rises[0], 10);
        else chk("pair_rises", rises.size(), 2);

        cmds.delete();
        step();
        switch[14] = 1'b1;
        wait_cmd("coal", 5'd7);
        step();
        switch[5] = 1'b1;
        step();
        switch[5] = 1'b0;
        wait_idle("coal");
        exp_q = {7};
        check_cmds("coal");

        cmds.delete();
        step();
        switch[2] = 1'b1;
        switch[11] = 1'b1;
        wait_cmd("rsy", 5'd10);
        step();
        resync_req = 1'b1;
        step();
        resync_req = 1'b0;
        wait_idle("rsy");
        exp_q = {10, 31};
        push_nondefault();
        check_cmds("rsy");
        chk("rsy_far", far, want());

        cmds.delete();
        step();
        switch[8] = 1'b1;
        wait_cmd("arst", 5'd13);
        step();
        reset_n = 1'b0;
        #1;
        chk("arst_ctl", control, 0);
        chk("arst_num", number, 31);
        chk("arst_busy", busy, 1);
        cmds.delete();
        repeat (2) @(negedge clk);
        step();
        reset_n = 1'b1;
        wait_idle("arst");
        exp_q = {31};
        push_nondefault();
        check_cmds("arst");
        chk("arst_far", far, want());

        for (int r = 0; r < 24; r++) begin
            k = $urandom_range(1, 3);
            for (int f = 0; f < k; f++) begin
                idx = $urandom_range(0, 21);
                if (idx < 4) button[3-idx] = ~button[3-idx];
                else switch[21-idx] = ~switch[21-idx];
            end
            if ($urandom_range(0, 5) == 0) begin
                resync_req = 1'b1;
                step();
                resync_req = 1'b0;
            end
            repeat ($urandom_range(1, 25)) step();
            if (r % 4 == 3) begin
                wait_idle($sformatf("rnd%0d", r));
                chk($sformatf("rnd%0d_far", r), far, want());
            end
        end
        wait_idle("final");
        chk("final_far", far, want());

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
